// File: rtl/clock_time_ctrl_pkg.sv
// Shared types and constants for the digital clock time-keeping slice.
//   mode_e  : operating mode; the encoding is also the value on the mode port
//   *_MAX   : packed-BCD wrap limits of the seconds, minutes and hours fields
//   bcd_inc : increments a packed-BCD byte by one, without the field wrap
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2
  } mode_e;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  // A low digit of 9 rolls over to 0 and carries into the high digit. The
  // field limit is applied by the caller.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Front-panel buttons and display-facing outputs of the clock controller.
//   btn_mode, btn_inc : single-cycle debounced button pulses
//   hh, mm, ss        : packed-BCD time fields
//   mode              : current operating mode
//   blink             : blanking request for the field being edited
//   sec_tick          : one-cycle pulse in the cycle a new seconds value appears
// master : panel/display side (drives buttons); slave : the controller.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  mode_e      mode;
  logic       blink;
  logic       sec_tick;

  modport master (
    output btn_mode, btn_inc,
    input  hh, mm, ss, mode, blink, sec_tick
  );

  modport slave (
    input  btn_mode, btn_inc,
    output hh, mm, ss, mode, blink, sec_tick
  );
endinterface

// File: rtl/clock_time_ctrl_bcd_mod_cnt.sv
// Two-digit packed-BCD counter that wraps from MAX back to 00.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 00, takes priority over inc
//   inc      : advance by one
//   value    : registered count
//   wrap     : combinational, inc && value == MAX; feeds the next field's carry
module bcd_mod_cnt
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q, value_d;

  assign wrap  = inc && (value_q == MAX);
  assign value = value_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    value_d = value_q;
    if (clr)       value_d = '0;
    else if (wrap) value_d = '0;
    else if (inc)  value_d = bcd_inc(value_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Mode and time-keeping controller for the digital clock.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of clock_time_ctrl_if (buttons in, display outputs)
// Derives a once-per-second tick from a TICK_DIV prescaler, runs the
// ss -> mm -> hh carry chain in RUN, and steers btn_inc onto hh or mm in the
// set modes. All outputs come straight from flops.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  clock_time_ctrl_if.slave  bus
);

  localparam int PSC_W = $clog2(TICK_DIV);
  localparam int HALF  = TICK_DIV / 2;
  // Keep at least one bit when TICK_DIV == 2 makes the half period a single cycle.
  localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

  mode_e            mode_q, mode_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_q, blink_d;
  logic             sec_tick_q, sec_tick_d;

  logic psc_wrap, run_tick, inc_eff, entering_set, leaving_mm;
  logic ss_inc, mm_inc, hh_inc;
  logic ss_wrap, mm_wrap, hh_wrap_unused;

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:    if (bus.btn_mode) mode_d = MODE_SET_HH;
      MODE_SET_HH: if (bus.btn_mode) mode_d = MODE_SET_MM;
      MODE_SET_MM: if (bus.btn_mode) mode_d = MODE_RUN;
      default:     mode_d = MODE_RUN;  // unused encoding recovers to RUN
    endcase

    psc_wrap = (psc_q == PSC_W'(TICK_DIV - 1));
    // A tick coinciding with leaving RUN is dropped so sec_tick never shows in a set mode.
    run_tick = (mode_q == MODE_RUN) && !bus.btn_mode && psc_wrap;

    // Held at 0 outside RUN, so returning to RUN restarts a full second.
    if (mode_q != MODE_RUN || mode_d != MODE_RUN) psc_d = '0;
    else if (psc_wrap)                            psc_d = '0;
    else                                          psc_d = psc_q + PSC_W'(1);

    // Mode advance wins over a same-cycle increment.
    inc_eff      = bus.btn_inc && !bus.btn_mode;
    entering_set = (mode_d != MODE_RUN) && (mode_d != mode_q);
    leaving_mm   = (mode_q == MODE_SET_MM) && (mode_d == MODE_RUN);

    // Carry chain in RUN; button source in the matching set mode.
    ss_inc = run_tick;
    mm_inc = (mode_q == MODE_RUN) ? ss_wrap : ((mode_q == MODE_SET_MM) && inc_eff);
    hh_inc = (mode_q == MODE_RUN) ? mm_wrap : ((mode_q == MODE_SET_HH) && inc_eff);

    // Blanked immediately on entry to each set mode, then toggles every HALF cycles.
    blink_d   = blink_q;
    blk_cnt_d = blk_cnt_q;
    if (mode_d == MODE_RUN) begin
      blink_d   = 1'b0;
      blk_cnt_d = '0;
    end else if (entering_set) begin
      blink_d   = 1'b1;
      blk_cnt_d = '0;
    end else if (blk_cnt_q == BLK_W'(HALF - 1)) begin
      blink_d   = ~blink_q;
      blk_cnt_d = '0;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end

    sec_tick_d = run_tick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      psc_q      <= '0;
      blk_cnt_q  <= '0;
      blink_q    <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      psc_q      <= psc_d;
      blk_cnt_q  <= blk_cnt_d;
      blink_q    <= blink_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  bcd_mod_cnt #(.MAX(SEC_MAX)) u_ss (
    .clk(clk), .rst(rst), .clr(leaving_mm), .inc(ss_inc),
    .value(bus.ss), .wrap(ss_wrap)
  );

  bcd_mod_cnt #(.MAX(MIN_MAX)) u_mm (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(mm_inc),
    .value(bus.mm), .wrap(mm_wrap)
  );

  bcd_mod_cnt #(.MAX(HR_MAX)) u_hh (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(hh_inc),
    .value(bus.hh), .wrap(hh_wrap_unused)
  );

  assign bus.mode     = mode_q;
  assign bus.blink    = blink_q;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICK_DIV=4. Expected display states
// are queued as each step is driven and compared once the step has completed.
module tb_clock_time_ctrl;
  import clock_pkg::*;

  typedef struct {
    string      tag;
    logic [7:0] hh, mm, ss;
    logic [1:0] mode;
    logic       blink;
    logic       chk_blink;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic tick_seen;
  exp_t sb[$];

  clock_time_ctrl_if bus ();

  clock_time_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                      input logic [7:0] ss, input logic [1:0] mode, input logic blink,
                      input logic chk_blink, input logic tick);
    exp_t e;
    e.tag = tag; e.hh = hh; e.mm = mm; e.ss = ss; e.mode = mode;
    e.blink = blink; e.chk_blink = chk_blink; e.tick = tick;
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".hh"},   bus.hh, e.hh);
      check({e.tag, ".mm"},   bus.mm, e.mm);
      check({e.tag, ".ss"},   bus.ss, e.ss);
      check({e.tag, ".mode"}, 8'(bus.mode), 8'(e.mode));
      check({e.tag, ".tick"}, 8'(bus.sec_tick), 8'(e.tick));
      if (e.chk_blink) check({e.tag, ".blink"}, 8'(bus.blink), 8'(e.blink));
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_mode();
    bus.btn_mode = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
  endtask

  // n separate btn_inc pulses, each followed by an idle cycle.
  task automatic inc_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_inc = 1'b1;
      step(1);
      if (bus.sec_tick) tick_seen = 1'b1;
      bus.btn_inc = 1'b0;
      step(1);
      if (bus.sec_tick) tick_seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    tick_seen    = 1'b0;

    step(3);
    push("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); compare_pop();
    @(negedge clk);
    rst = 1'b0;

    // First second and first minute from reset.
    push("pre_first_tick", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); step(3);   compare_pop();
    push("first_tick",     8'h00, 8'h00, 8'h01, 2'd0, 1'b0, 1'b1, 1'b1); step(1);   compare_pop();
    push("tick_one_cycle", 8'h00, 8'h00, 8'h01, 2'd0, 1'b0, 1'b1, 1'b0); step(1);   compare_pop();
    push("first_minute",   8'h00, 8'h01, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1); step(235); compare_pop();

    // Preload 23:59 and run into the full carry.
    push("enter_set_hh", 8'h00, 8'h01, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0); pulse_mode();    compare_pop();
    push("hh_set_23",    8'h23, 8'h01, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0); inc_pulses(23);  compare_pop();
    push("enter_set_mm", 8'h23, 8'h01, 8'h00, 2'd2, 1'b1, 1'b1, 1'b0); pulse_mode();    compare_pop();
    push("mm_set_59",    8'h23, 8'h59, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0); inc_pulses(58);  compare_pop();
    push("back_to_run",  8'h23, 8'h59, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); pulse_mode();    compare_pop();
    push("at_58",        8'h23, 8'h59, 8'h58, 2'd0, 1'b0, 1'b1, 1'b1); step(232);       compare_pop();
    push("at_59",        8'h23, 8'h59, 8'h59, 2'd0, 1'b0, 1'b1, 1'b1); step(4);         compare_pop();
    push("hold_59",      8'h23, 8'h59, 8'h59, 2'd0, 1'b0, 1'b1, 1'b0); step(3);         compare_pop();
    push("full_carry",   8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1); step(1);         compare_pop();

    // Hours wrap in SET_HH with no tick activity.
    push("set_hh_again", 8'h00, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0); pulse_mode();    compare_pop();
    tick_seen = 1'b0;
    push("hh_wrap_25",   8'h01, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0); inc_pulses(25);  compare_pop();
    check("no_tick_in_set_hh", 8'(tick_seen), 8'h00);

    // Minutes wrap in SET_MM without carrying, then restart of the second.
    tick_seen = 1'b0;
    push("enter_mm2",    8'h01, 8'h00, 8'h00, 2'd2, 1'b1, 1'b1, 1'b0); pulse_mode();    compare_pop();
    push("mm_59",        8'h01, 8'h59, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0); inc_pulses(59);  compare_pop();
    push("mm_wrap",      8'h01, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0); inc_pulses(1);   compare_pop();
    check("no_tick_in_set_mm", 8'(tick_seen), 8'h00);
    push("run_again",    8'h01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); pulse_mode();    compare_pop();
    push("no_tick_yet",  8'h01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); step(3);        compare_pop();
    push("tick_after_4", 8'h01, 8'h00, 8'h01, 2'd0, 1'b0, 1'b1, 1'b1); step(1);        compare_pop();

    // Simultaneous buttons: mode wins; then the blink cadence.
    push("simul_btn",    8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 1'b1, 1'b0);
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    compare_pop();
    push("blink_c1", 8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 1'b1, 1'b0); step(1); compare_pop();
    push("blink_c2", 8'h01, 8'h00, 8'h01, 2'd1, 1'b0, 1'b1, 1'b0); step(1); compare_pop();
    push("blink_c3", 8'h01, 8'h00, 8'h01, 2'd1, 1'b0, 1'b1, 1'b0); step(1); compare_pop();
    push("blink_c4", 8'h01, 8'h00, 8'h01, 2'd1, 1'b1, 1'b1, 1'b0); step(1); compare_pop();

    // Leaving SET_MM clears a non-zero seconds value.
    push("to_set_mm",  8'h01, 8'h00, 8'h01, 2'd2, 1'b1, 1'b1, 1'b0); pulse_mode(); compare_pop();
    push("ss_cleared", 8'h01, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); pulse_mode(); compare_pop();

    // Asynchronous reset in the middle of SET_HH.
    push("set_hh3", 8'h01, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0); pulse_mode();   compare_pop();
    push("hh_15",   8'h15, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0); inc_pulses(14); compare_pop();
    rst = 1'b1;
    #1;
    push("async_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); compare_pop();
    #1;
    rst = 1'b0;
    push("resume_pre",  8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0); step(3); compare_pop();
    push("resume_tick", 8'h00, 8'h00, 8'h01, 2'd0, 1'b0, 1'b1, 1'b1); step(1); compare_pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
